// File: rtl/ram_ctrl.sv
// Byte-addressed on-chip RAM slave for the CPU bus: 8-byte big-endian reads and
// writes with programmable latency and a registered ready/error handshake.
//
// state | meaning
// IDLE  | waiting for ram_cs; request latched on the accepting edge
// BUSY  | latency countdown; ram_cs dropping here aborts the access
// RESP  | one-cycle ready (and error) pulse; writes commit at the end of it
// HOLD  | waiting for ram_cs to drop before the next access
module ram_ctrl #(
  parameter int DEPTH_BYTES = 4096,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_addr,
  inout  wire  [63:0] bus_data,
  input  logic        ram_cs,
  input  logic        ram_we,
  input  logic        ram_oe,
  output logic        ram_ready,
  output logic        ram_err
);

  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam logic [63:0] LAST_BASE = 64'(DEPTH_BYTES - 8);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [15:0]   cnt;
  logic [AW-1:0] addr_q;
  logic [63:0]   data_q;
  logic [63:0]   rdata;
  logic          wr_q;
  logic          rd_q;
  logic          err_q;

  logic          acc_ill;
  logic          acc_oor;
  logic          acc_err;
  logic          acc_wr;
  logic          acc_rd;
  logic [15:0]   acc_cnt;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [63:0]   rd_word;
  logic          drive;

  // Range test avoids addr+7, which could wrap for addresses near 2^64.
  always_comb begin
    acc_ill = (ram_we == ram_oe);
    acc_oor = (bus_addr > LAST_BASE);
    acc_err = acc_ill || acc_oor;
    acc_wr  = ram_we && !ram_oe && !acc_oor;
    acc_rd  = ram_oe && !ram_we && !acc_oor;
    if (acc_ill)
      acc_cnt = '0;
    else if (ram_we)
      acc_cnt = 16'(WR_LAT - 1);
    else
      acc_cnt = 16'(RD_LAT - 1);
  end

  // A latency-1 read enters RESP on the accepting edge, before addr_q is valid.
  always_comb begin
    rd_addr = (state == IDLE) ? bus_addr[AW-1:0] : addr_q;
    rd_en   = (state == IDLE) ? acc_rd : rd_q;
    rd_word = '0;
    if (rd_en) begin
      for (int i = 0; i < 8; i++)
        rd_word[63-8*i -: 8] = mem[rd_addr + AW'(i)];
    end
  end

  assign drive    = ((state == RESP) || (state == HOLD)) && ram_cs && ram_oe && !ram_we;
  assign bus_data = drive ? rdata : 64'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ram_ready <= 1'b0;
      ram_err   <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ram_ready <= 1'b0;
      ram_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (ram_cs) begin
            addr_q <= bus_addr[AW-1:0];
            if (ram_we)
              data_q <= bus_data;
            wr_q  <= acc_wr;
            rd_q  <= acc_rd;
            err_q <= acc_err;
            cnt   <= acc_cnt;
            if (acc_cnt != '0) begin
              state <= BUSY;
            end else begin
              state     <= RESP;
              ram_ready <= 1'b1;
              ram_err   <= acc_err;
              rdata     <= rd_word;
            end
          end
        end
        BUSY: begin
          if (!ram_cs) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              state     <= RESP;
              ram_ready <= 1'b1;
              ram_err   <= err_q;
              rdata     <= rd_word;
            end
          end
        end
        RESP: state <= HOLD;
        HOLD: if (!ram_cs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never reset; a reset landing in RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && wr_q) begin
      for (int i = 0; i < 8; i++)
        mem[addr_q + AW'(i)] <= data_q[63-8*i -: 8];
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed vector table, abort/hold sequences
// and a randomized run against a byte-array reference model.
module tb_ram_ctrl;

  localparam int          DEPTH    = 4096;
  localparam int          RLAT     = 2;
  localparam int          WLAT     = 1;
  localparam logic [63:0] BUS_IDLE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        cs = 1'b0, we = 1'b0, oe = 1'b0, wen = 1'b0, sel = 1'b0;
  tri1  [63:0] bus0, bus1;
  logic        ready0, err0, ready1, err1;
  logic        cs0, cs1, obs_ready, obs_err;
  logic [63:0] obs_bus;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  assign bus0      = (wen && !sel) ? wdata : 64'bz;
  assign bus1      = (wen && sel) ? wdata : 64'bz;
  assign cs0       = cs && !sel;
  assign cs1       = cs && sel;
  assign obs_ready = sel ? ready1 : ready0;
  assign obs_err   = sel ? err1 : err0;
  assign obs_bus   = sel ? bus1 : bus0;

  ram_ctrl #(.DEPTH_BYTES(DEPTH), .RD_LAT(RLAT), .WR_LAT(WLAT)) u_dut (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_data(bus0),
    .ram_cs(cs0), .ram_we(we), .ram_oe(oe), .ram_ready(ready0), .ram_err(err0));

  ram_ctrl #(.DEPTH_BYTES(DEPTH), .RD_LAT(RLAT), .WR_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_data(bus1),
    .ram_cs(cs1), .ram_we(we), .ram_oe(oe), .ram_ready(ready1), .ram_err(err1));

  typedef struct {
    logic        we;
    logic        oe;
    logic [63:0] addr;
    logic [63:0] data;
    int          lat;
    logic        err;
    logic [63:0] rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full bus transaction; ram_cs is held hold_n cycles past the ready pulse.
  task automatic do_txn(input logic s, input logic w, input logic o,
                        input logic [63:0] a, input logic [63:0] d, input int hold_n,
                        output int lat, output logic e, output logic [63:0] rd,
                        output logic [63:0] hold_rd, output int extra);
    @(negedge clk);
    sel = s; addr = a; we = w; oe = o; wdata = d; wen = w; cs = 1'b1;
    lat = 0; e = 1'b0; rd = '0; hold_rd = '0; extra = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (obs_ready) begin
        lat = n; e = obs_err; rd = obs_bus;
        break;
      end
    end
    for (int h = 0; h < hold_n; h++) begin
      @(negedge clk);
      if (obs_ready) extra++;
      hold_rd = obs_bus;
    end
    cs = 1'b0; wen = 1'b0;
  endtask

  // Reference: transaction-level rules on a plain byte array.
  task automatic model_txn(input logic w, input logic o, input logic [63:0] a,
                           input logic [63:0] d, output int lat, output logic e,
                           output logic [63:0] rd);
    logic ill, oor;
    ill = (w && o) || (!w && !o);
    oor = ({1'b0, a} + 65'd7) >= 65'(DEPTH);
    lat = ill ? 1 : (w ? WLAT : RLAT);
    e   = ill || oor;
    if (o && !w) begin
      rd = '0;
      if (!oor)
        for (int i = 0; i < 8; i++) rd = {rd[55:0], model_mem[int'(a) + i]};
    end else if (w) begin
      rd = d;
    end else begin
      rd = BUS_IDLE;
    end
    if (w && !o && !oor)
      for (int i = 0; i < 8; i++) model_mem[int'(a) + i] = d[63-8*i -: 8];
  endtask

  initial begin
    int          lat, extra, pulses, elat;
    logic        e, eerr;
    logic [63:0] rd, hrd, erd, a, d;
    logic        w, o;
    int          r;

    vecs[0]  = '{1'b1, 1'b0, 64'h18,  64'hDEADBEEF01020304, 1, 1'b0, 64'hDEADBEEF01020304};
    vecs[1]  = '{1'b1, 1'b0, 64'h10,  64'h0011223344556677, 1, 1'b0, 64'h0011223344556677};
    vecs[2]  = '{1'b0, 1'b1, 64'h10,  64'h0,                2, 1'b0, 64'h0011223344556677};
    vecs[3]  = '{1'b0, 1'b1, 64'h14,  64'h0,                2, 1'b0, 64'h44556677DEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 64'hFF8, 64'hA0A1A2A3A4A5A6A7, 1, 1'b0, 64'hA0A1A2A3A4A5A6A7};
    vecs[5]  = '{1'b0, 1'b1, 64'hFF9, 64'h0,                2, 1'b1, 64'h0};
    vecs[6]  = '{1'b1, 1'b0, 64'hFF9, 64'h5A5A5A5A5A5A5A5A, 1, 1'b1, 64'h5A5A5A5A5A5A5A5A};
    vecs[7]  = '{1'b0, 1'b1, 64'hFF8, 64'h0,                2, 1'b0, 64'hA0A1A2A3A4A5A6A7};
    vecs[8]  = '{1'b1, 1'b1, 64'h10,  64'h9988776655443322, 1, 1'b1, 64'h9988776655443322};
    vecs[9]  = '{1'b0, 1'b1, 64'h10,  64'h0,                2, 1'b0, 64'h0011223344556677};
    vecs[10] = '{1'b0, 1'b0, 64'h10,  64'h0,                1, 1'b1, BUS_IDLE};
    vecs[11] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2, 1'b1, 64'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d ready", c), {63'b0, ready0}, 64'h0);
      chk($sformatf("idle%0d err", c), {63'b0, err0}, 64'h0);
      chk($sformatf("idle%0d bus", c), bus0, BUS_IDLE);
    end

    foreach (vecs[i]) begin
      do_txn(1'b0, vecs[i].we, vecs[i].oe, vecs[i].addr, vecs[i].data, 1, lat, e, rd, hrd, extra);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d err", i), {63'b0, e}, {63'b0, vecs[i].err});
      chk($sformatf("vec%0d resp_data", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d hold_data", i), hrd, vecs[i].rd);
      chk($sformatf("vec%0d extra_ready", i), 64'(extra), 64'h0);
    end

    // Held ram_cs must not retrigger.
    do_txn(1'b0, 1'b0, 1'b1, 64'h10, 64'h0, 5, lat, e, rd, hrd, extra);
    chk("hold5 latency", 64'(lat), 64'd2);
    chk("hold5 extra_ready", 64'(extra), 64'h0);
    chk("hold5 data", hrd, 64'h0011223344556677);

    // Abort cases on the WR_LAT=3 instance.
    do_txn(1'b1, 1'b1, 1'b0, 64'h40, 64'h1122334455667788, 1, lat, e, rd, hrd, extra);
    chk("lat3 write latency", 64'(lat), 64'd3);
    chk("lat3 write err", {63'b0, e}, 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sel = 1'b1; addr = 64'h40; we = 1'b1; oe = 1'b0;
      wdata = 64'hCAFEF00DCAFEF00D; wen = 1'b1; cs = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        cs = 1'b0; wen = 1'b0;
      end else begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; cs = 1'b0; wen = 1'b0;
      end
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (ready1) pulses++;
      end
      chk($sformatf("abort%0d ready_pulses", k), 64'(pulses), 64'h0);
      do_txn(1'b1, 1'b0, 1'b1, 64'h40, 64'h0, 1, lat, e, rd, hrd, extra);
      chk($sformatf("abort%0d mem_unchanged", k), rd, 64'h1122334455667788);
      chk($sformatf("abort%0d read_latency", k), 64'(lat), 64'd2);
    end

    // Randomized run: preload every byte the random addresses can read.
    for (int b = 0; b <= 256; b += 8) begin
      d = {$urandom, $urandom};
      model_txn(1'b1, 1'b0, 64'(b), d, elat, eerr, erd);
      do_txn(1'b0, 1'b1, 1'b0, 64'(b), d, 1, lat, e, rd, hrd, extra);
      chk("preload err", {63'b0, e}, {63'b0, eerr});
    end
    for (int b = 4080; b <= 4088; b += 8) begin
      d = {$urandom, $urandom};
      model_txn(1'b1, 1'b0, 64'(b), d, elat, eerr, erd);
      do_txn(1'b0, 1'b1, 1'b0, 64'(b), d, 1, lat, e, rd, hrd, extra);
      chk("preload_top err", {63'b0, e}, {63'b0, eerr});
    end
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 64'($urandom_range(0, 256));
      else if (r < 9) a = 64'($urandom_range(4080, 4095));
      else            a = {1'b1, 31'($urandom), 32'($urandom)};
      r = $urandom_range(0, 9);
      w = (r >= 4 && r <= 8);
      o = (r <= 3 || r == 8);
      d = {$urandom, $urandom};
      model_txn(w, o, a, d, elat, eerr, erd);
      do_txn(1'b0, w, o, a, d, $urandom_range(1, 3), lat, e, rd, hrd, extra);
      chk($sformatf("rnd%0d latency", t), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d err", t), {63'b0, e}, {63'b0, eerr});
      chk($sformatf("rnd%0d data", t), rd, erd);
      chk($sformatf("rnd%0d hold_data", t), hrd, erd);
      chk($sformatf("rnd%0d extra_ready", t), 64'(extra), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
